// File: rtl/store_unit_if.sv
// Store request and memory write-beat signal bundle for store_unit.
// Latency: none (wires only).
// Backpressure: req_ready and mem_ack are the two flow-control returns.
interface store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_ack;
    logic        done;
    logic        err;

    // Environment side: issues store requests and plays the memory.
    modport master (
        output req_valid, funct3, addr, wdata, mem_ack,
        input  req_ready, mem_req, mem_addr, mem_wdata, mem_we, done, err
    );

    // Store unit side.
    modport slave (
        input  req_valid, funct3, addr, wdata, mem_ack,
        output req_ready, mem_req, mem_addr, mem_wdata, mem_we, done, err
    );
endinterface

// File: rtl/store_unit.sv
// Store unit: turns SB/SH/SW requests into lane-aligned word write beats (STORE_MISALIGN_SPLIT_EN enables a 2-beat split for word-crossing stores).
// Latency: accept at T, first beat at T+1, done/err pulse the cycle after the final ack, timeout or rejection.
// Backpressure: req_ready only in IDLE; each beat holds until mem_ack or ACK_TIMEOUT cycles elapse.
module store_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_t;

    localparam logic [32:0] TMO_LIMIT = {1'b0, 32'(ACK_TIMEOUT)};

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] tmo_q, tmo_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic [3:0]  req_mask;
    logic        req_legal;
    logic        req_reject;

    logic [3:0]  lat_mask;
    logic [31:0] lat_masked;
    logic [31:0] beat_base;
    logic [3:0]  beat0_we;
    logic [31:0] beat0_dat;
    logic        tmo_hit;

    assign bus.req_ready = (state_q == IDLE);
    assign accept        = bus.req_valid && (state_q == IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    // Classify the presented request: base lane mask and legality of funct3.
    always_comb begin
        req_mask  = 4'b0000;
        req_legal = 1'b1;
        case (bus.funct3)
            3'b000:  req_mask = 4'b0001;
            3'b001:  req_mask = 4'b0011;
            3'b010:  req_mask = 4'b1111;
            default: req_legal = 1'b0;
        endcase
    end

`ifdef STORE_MISALIGN_SPLIT_EN
    assign req_reject = !req_legal;
`else
    // A request whose lanes spill past byte 3 cannot be issued as one beat.
    logic [7:0] req_mask_sh;
    assign req_mask_sh = {4'b0000, req_mask} << bus.addr[1:0];
    assign req_reject  = !req_legal || (req_mask_sh[7:4] != 4'b0000);
`endif

    // Lane mask of the latched request; unused byte lanes are zeroed before shifting.
    always_comb begin
        lat_mask = 4'b0000;
        case (funct3_q)
            3'b000:  lat_mask = 4'b0001;
            3'b001:  lat_mask = 4'b0011;
            3'b010:  lat_mask = 4'b1111;
            default: lat_mask = 4'b0000;
        endcase
    end

    assign lat_masked = wdata_q & {{8{lat_mask[3]}}, {8{lat_mask[2]}},
                                   {8{lat_mask[1]}}, {8{lat_mask[0]}}};
    assign beat_base  = {addr_q[31:2], 2'b00};

`ifdef STORE_MISALIGN_SPLIT_EN
    logic [7:0]  lat_we_sh;
    logic [63:0] lat_dat_sh;
    logic [31:0] beat1_addr;
    assign lat_we_sh  = {4'b0000, lat_mask} << addr_q[1:0];
    assign lat_dat_sh = {32'h0, lat_masked} << {addr_q[1:0], 3'b000};
    assign beat0_we   = lat_we_sh[3:0];
    assign beat0_dat  = lat_dat_sh[31:0];
    assign beat1_addr = beat_base + 32'd4;
`else
    assign beat0_we   = lat_mask << addr_q[1:0];
    assign beat0_dat  = lat_masked << {addr_q[1:0], 3'b000};
`endif

    // Beat gives up once this cycle would be the ACK_TIMEOUT-th without an ack.
    assign tmo_hit = ({1'b0, tmo_q} + 33'd1) >= TMO_LIMIT;

    // State register; reset abandons any beat in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, timeout counter update and completion/abort pulses.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = 32'd0;
                if (accept) begin
                    if (req_reject) err_d   = 1'b1;
                    else            state_d = WR0;
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            WR0, WR1: begin
`else
            WR0: begin
`endif
                if (bus.mem_ack) begin
                    tmo_d = 32'd0;
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (state_q == WR0 && lat_we_sh[7:4] != 4'b0000) begin
                        state_d = WR1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else if (tmo_hit) begin
                    tmo_d   = 32'd0;
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured on acceptance and held until the store ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else if (accept) begin
            funct3_q <= bus.funct3;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
        end
    end

    // Timeout counter and the registered done/err pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q  <= 32'd0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Beat outputs decode straight from state so reset drops mem_req at once.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_we    = 4'b0000;
        bus.mem_wdata = 32'h0;
        case (state_q)
            WR0: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = beat_base;
                bus.mem_we    = beat0_we;
                bus.mem_wdata = beat0_dat;
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            WR1: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = beat1_addr;
                bus.mem_we    = lat_we_sh[7:4];
                bus.mem_wdata = lat_dat_sh[63:32];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, is the maximum number of cycles a memory beat waits for mem_ack before aborting.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  a store request is presented.
REQ-005 req_ready  output  1  the unit can accept a request.
REQ-006 funct3  input  3  store type: SB=000, SH=001, SW=010.
REQ-007 addr  input  32  byte address (rv1 + imm).
REQ-008 wdata  input  32  store data (rv2).
REQ-009 mem_req  output  1  write beat valid.
REQ-010 mem_addr  output  32  word-aligned beat address; bits [1:0] are always 00.
REQ-011 mem_wdata  output  32  lane-aligned write data.
REQ-012 mem_we  output  4  byte-lane write enables; bit i enables byte i.
REQ-013 mem_ack  input  1  memory accepted the current beat.
REQ-014 done  output  1  one-cycle pulse: the store completed.
REQ-015 err  output  1  one-cycle pulse: the store was aborted.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, WR0, WR1; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted when req_valid&&req_ready; funct3, addr and wdata SHALL be latched on acceptance and held stable internally until the store completes.
REQ-018 Lane mask SHALL be: SB=0001, SH=0011, SW=1111; with off=addr[1:0], shifted mask = mask<<off (8 bits) and shifted data = wdata<<(8*off) (64 bits); lanes with a 0 enable SHALL carry 0 in mem_wdata.
REQ-019 A store SHALL be single-beat when shifted mask[7:4]==0; WR0 then drives mem_addr={addr[31:2],00}, mem_we=shifted mask[3:0], mem_wdata=shifted data[31:0].
REQ-020 In WR0 and WR1, mem_req SHALL be 1 and mem_addr/mem_wdata/mem_we SHALL stay stable until mem_ack is sampled 1.
REQ-021 On mem_ack in the final beat, the FSM SHALL return to IDLE, and done SHALL be 1 in the following cycle with req_ready=1, so back-to-back acceptance is possible.
REQ-022 Minimum latency SHALL be: accept at cycle T, mem_req at T+1, done at T+2 when mem_ack=1 at T+1.
REQ-023 Illegal funct3 (any value other than 000/001/010) SHALL cause no memory beat; err SHALL pulse in the cycle after acceptance and the FSM SHALL stay in IDLE.
REQ-024 A 32-bit timeout counter SHALL clear on entry to each beat and increment every cycle without mem_ack; reaching ACK_TIMEOUT SHALL drop mem_req, pulse err the next cycle and return to IDLE, and no done SHALL be issued.
REQ-025 done and err SHALL never be 1 in the same cycle; mem_ack outside WR0/WR1 SHALL be ignored.

Reset
REQ-026 While reset=0, outputs SHALL be: state=IDLE, req_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_we=0000, done=0, err=0, timeout counter=0.
REQ-027 Reset asserted mid-beat SHALL drop mem_req immediately (asynchronously), abandon the store and emit neither done nor err.

Configuration
REQ-028 With STORE_MISALIGN_SPLIT_EN defined, a store with shifted mask[7:4]!=0 SHALL issue WR0 (lanes [3:0], data [31:0]), then WR1 with mem_addr={addr[31:2],00}+4 modulo 2^32, mem_we=shifted mask[7:4], mem_wdata=shifted data[63:32]; done SHALL follow the WR1 ack; a WR0 timeout SHALL skip WR1.
REQ-029 Without STORE_MISALIGN_SPLIT_EN, such a store SHALL issue no beat, and err SHALL pulse in the cycle after acceptance; WR1 logic SHALL not be present.

Verification
REQ-030 SB, addr=0x00100002, wdata=0xF1F2F3F4, mem_ack tied 1 -> one beat: mem_addr=0x00100000, mem_we=0100, mem_wdata=0x00F40000; done at T+2.
REQ-031 SH, addr=0x00100002, wdata=0x1F2F3F4F -> mem_we=1100, mem_wdata=0x3F4F0000; SW, addr=0x00100000 -> mem_we=1111, mem_wdata=wdata.
REQ-032 SW, addr=0xFFFFFFFD, wdata=0xAABBCCDD: with macro -> beat0 addr=0xFFFFFFFC we=1110 data=0xBBCCDD00, beat1 addr=0x00000000 we=0001 data=0x000000AA, then done; without macro -> no mem_req, err pulse at T+1.
REQ-033 funct3=011 -> no mem_req, err at T+1; mem_ack held 0 with ACK_TIMEOUT=4 -> mem_req drops after 4 cycles, err pulses once, no done.
REQ-034 mem_ack delayed 3 cycles -> beat outputs stable for all 4 cycles; reset pulled low during WR0 -> mem_req=0 at once, no done/err, and the next request proceeds normally.
